// File: rtl/wb_intercon_reg.sv
// Registered single-master Wishbone interconnect: decodes the top address bits to a slave,
// holds the request stable while BUSY, and returns a bus error on unmapped hits or ACK timeout.
module wb_intercon_reg #(
  parameter int              AW       = 32,
  parameter int              DW       = 32,
  parameter int              N_SLAVES = 16,
  parameter int              SEL_BITS = 4,
  parameter int              TIMEOUT  = 255,
  parameter logic [DW-1:0]   ERR_DATA = 32'hDEADBEEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   master_STB,
  input  logic                   master_WE,
  input  logic [AW-1:0]          master_ADDR,
  input  logic [DW-1:0]          master_DAT_I,
  output logic [DW-1:0]          master_DAT_O,
  output logic                   master_ACK,
  output logic                   master_ERR,
  output logic [AW-1:0]          err_addr,
  output logic [N_SLAVES-1:0]    slave_STB,
  input  logic [N_SLAVES-1:0]    slave_ACK,
  output logic                   slave_WE,
  output logic [AW-1:0]          slave_ADDR,
  output logic [DW-1:0]          slave_DAT_O,
  input  logic [N_SLAVES*DW-1:0] slave_DAT_I
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP, ERR} state_t;

  state_t                state_reg;
  logic [SEL_BITS-1:0]   idx_reg;
  logic [CW-1:0]         cnt_reg;

  logic [SEL_BITS-1:0]   req_idx;
  logic                  req_mapped;
  logic [N_SLAVES-1:0]   req_onehot;
  logic [N_SLAVES-1:0]   sel_onehot;
  logic                  sel_ack;
  logic [DW-1:0]         sel_data;

  assign req_idx    = master_ADDR[AW-1 -: SEL_BITS];
  // One extra bit so N_SLAVES == 2**SEL_BITS still compares correctly.
  assign req_mapped = ({1'b0, req_idx} < (SEL_BITS + 1)'(N_SLAVES));

  generate
    for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_dec
      assign req_onehot[gi] = (req_idx == SEL_BITS'(gi));
      assign sel_onehot[gi] = (idx_reg == SEL_BITS'(gi));
    end
  endgenerate

  // Only the latched slave's ACK and data are observed.
  assign sel_ack = |(slave_ACK & sel_onehot);

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (sel_onehot[i]) sel_data = slave_DAT_I[i*DW +: DW];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      cnt_reg      <= '0;
      master_DAT_O <= '0;
      master_ACK   <= 1'b0;
      master_ERR   <= 1'b0;
      err_addr     <= '0;
      slave_STB    <= '0;
      slave_WE     <= 1'b0;
      slave_ADDR   <= '0;
      slave_DAT_O  <= '0;
    end else begin
      master_ACK <= 1'b0;
      master_ERR <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (master_STB) begin
            if (req_mapped) begin
              idx_reg     <= req_idx;
              slave_ADDR  <= master_ADDR;
              slave_WE    <= master_WE;
              slave_DAT_O <= master_DAT_I;
              slave_STB   <= req_onehot;
              cnt_reg     <= '0;
              state_reg   <= BUSY;
            end else begin
              err_addr     <= master_ADDR;
              master_ERR   <= 1'b1;
              master_DAT_O <= ERR_DATA;
              state_reg    <= ERR;
            end
          end
        end
        BUSY: begin
          if (!master_STB) begin
            slave_STB <= '0;
            state_reg <= IDLE;
          end else if (sel_ack) begin
            master_DAT_O <= sel_data;
            master_ACK   <= 1'b1;
            slave_STB    <= '0;
            state_reg    <= RESP;
          end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
            err_addr     <= slave_ADDR;
            master_ERR   <= 1'b1;
            master_DAT_O <= ERR_DATA;
            slave_STB    <= '0;
            state_reg    <= ERR;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        RESP:    state_reg <= IDLE;
        ERR:     state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
